// File: rtl/spi_master_mc.sv
// Full-duplex SPI master: four CPOL/CPHA modes, 1..DATA_W-bit words, NUM_CS chip selects, CS hold.
// Define SPI_LSB_FIRST_EN to add the lsb_first input (LSB-first shifting); default build is MSB-first.
module spi_master_mc #(
    parameter  int DATA_W = 32,
    parameter  int NUM_CS = 4,
    parameter  int DIV_W  = 16,
    localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int LEN_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [LEN_W-1:0]  len_m1,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DIV_W-1:0]  clkdiv,
    input  logic              hold_cs,
    input  logic              cs_release,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic [NUM_CS-1:0] SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_BITS,
        S_TRAIL,
        S_HOLD
    } state_t;

    localparam logic [LEN_W-1:0] MAX_IDX = LEN_W'(DATA_W - 1);

    state_t              r_state;
    state_t              w_state_nx;
    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [LEN_W+1:0]    r_edge;
    logic [LEN_W-1:0]    r_len;
    logic                r_cpha;
    logic                r_cpol;
    logic [CS_W-1:0]     r_cs;
    logic                r_hold;
    logic [DATA_W-1:0]   r_sh;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_sclk;

    logic                w_tick;
    logic                w_accept;
    logic                w_fire;
    logic                w_lead;
    logic                w_sample;
    logic                w_shift;
    logic                w_done;
    logic [LEN_W+1:0]    w_nedges;
    logic [NUM_CS-1:0]   w_ss_n;
    logic                w_lsb;
    logic                w_lsb_in;

`ifdef SPI_LSB_FIRST_EN
    logic                r_lsb;
    assign w_lsb    = r_lsb;
    assign w_lsb_in = lsb_first;
`else
    assign w_lsb    = 1'b0;
    assign w_lsb_in = 1'b0;
`endif

    // A word of len_m1+1 bits needs two SCLK edges per bit.
    assign w_nedges = {1'b0, r_len, 1'b0} + (LEN_W+2)'(2);
    assign w_tick   = (r_cnt == r_div);
    assign w_lead   = ~r_edge[0];
    assign w_done   = (r_state == S_TRAIL) && w_tick;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_fire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_fire     = 1'b1;
                    w_state_nx = S_BITS;
                end
            end
            S_BITS: begin
                if (w_tick) begin
                    if (r_edge == w_nedges) w_state_nx = S_TRAIL;
                    else                    w_fire     = 1'b1;
                end
            end
            S_TRAIL: begin
                if (w_tick) w_state_nx = r_hold ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (start) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_SETUP;
                end else if (cs_release) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Edge index r_edge is even for leading edges; cpha picks which kind samples and which shifts.
    assign w_sample = w_fire & (w_lead ^ r_cpha);
    assign w_shift  = w_fire & (r_cpha ? (w_lead && (r_edge != '0))
                                       : (!w_lead && (r_edge != w_nedges - (LEN_W+2)'(1))));

    // NOTE: sequential state uses non-blocking assignments; the reset is synchronous and active-high.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div      <= '0;
            r_edge     <= '0;
            r_len      <= '0;
            r_cpha     <= 1'b0;
            r_cpol     <= 1'b0;
            r_cs       <= '0;
            r_hold     <= 1'b0;
            r_sh       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_sclk     <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
            r_lsb      <= 1'b0;
`endif
        end else begin
            r_rx_valid <= w_done;
            if (w_done) r_rx_data <= r_rx;
            if (w_accept) begin
                r_len  <= len_m1;
                r_cpha <= cpha;
                r_div  <= clkdiv;
                r_hold <= hold_cs;
                r_edge <= '0;
                r_cnt  <= '0;
                r_rx   <= '0;
                r_sh   <= w_lsb_in ? tx_data : (tx_data << (MAX_IDX - len_m1));
`ifdef SPI_LSB_FIRST_EN
                r_lsb  <= lsb_first;
`endif
                // Polarity and chip select may only change while SS_n is deasserted.
                if (r_state == S_IDLE) begin
                    r_cpol <= cpol;
                    r_cs   <= cs_sel;
                    r_sclk <= cpol;
                end
            end else begin
                if (w_tick || (w_state_nx != r_state) || !busy) r_cnt <= '0;
                else                                           r_cnt <= r_cnt + DIV_W'(1);
                if (w_fire) begin
                    r_sclk <= ~r_sclk;
                    r_edge <= r_edge + (LEN_W+2)'(1);
                end
                if (w_sample) begin
                    r_rx <= w_lsb ? ((r_rx >> 1) | (DATA_W'(MISO) << r_len))
                                  : {r_rx[DATA_W-2:0], MISO};
                end
                if (w_shift) r_sh <= w_lsb ? (r_sh >> 1) : (r_sh << 1);
            end
        end
    end

    always_comb begin
        w_ss_n = '1;
        if (r_state != S_IDLE) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (r_cs == CS_W'(i)) w_ss_n[i] = 1'b0;
            end
        end
    end

    assign ready    = (r_state == S_IDLE) || (r_state == S_HOLD);
    assign busy     = (r_state == S_SETUP) || (r_state == S_BITS) || (r_state == S_TRAIL);
    assign SS_n     = w_ss_n;
    assign SCLK     = r_sclk;
    assign MOSI     = w_lsb ? r_sh[0] : r_sh[DATA_W-1];
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed self-checking bench for spi_master_mc: modes, lengths, dividers, CS hold, reset, busy-start.
module tb_spi_master_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] tx_data;
    logic [4:0]  len_m1;
    logic        cpol;
    logic        cpha;
    logic [1:0]  cs_sel;
    logic [15:0] clkdiv;
    logic        hold_cs;
    logic        cs_release;
`ifdef SPI_LSB_FIRST_EN
    logic        lsb_first;
`endif
    logic        ready;
    logic        busy;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [3:0]  ss_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        loopback;
    logic        miso_fix;

    int n_tests = 0;
    int n_fail  = 0;

    // Results of the most recent transfer.
    int          valid_cyc, rises, falls, first_edge;
    logic [31:0] rx_got;
    logic [3:0]  ss1, ss_v;
    logic        busy1, ready1, sclk1, mosi1, ready_v, sclk_v;

    assign miso = loopback ? mosi : miso_fix;

    spi_master_mc dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tx_data    (tx_data),
        .len_m1     (len_m1),
        .cpol       (cpol),
        .cpha       (cpha),
        .cs_sel     (cs_sel),
        .clkdiv     (clkdiv),
        .hold_cs    (hold_cs),
        .cs_release (cs_release),
`ifdef SPI_LSB_FIRST_EN
        .lsb_first  (lsb_first),
`endif
        .ready      (ready),
        .busy       (busy),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .SS_n       (ss_n),
        .SCLK       (sclk),
        .MOSI       (mosi),
        .MISO       (miso)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one start (accepted at the next edge = cycle 0) and follows the word to rx_valid.
    // poke > 0 pulses a conflicting start with different settings during that cycle.
    task automatic xfer(input logic [31:0] tx, input logic [4:0] len, input logic pol,
                        input logic pha, input logic [1:0] cs, input logic [15:0] div,
                        input logic hold, input int poke, input int max_cyc);
        int   cyc;
        logic prev;
        start = 1'b1; tx_data = tx; len_m1 = len; cpol = pol; cpha = pha;
        cs_sel = cs; clkdiv = div; hold_cs = hold;
        step();
        start = 1'b0;
        cyc = 1;
        busy1 = busy; ready1 = ready; ss1 = ss_n; sclk1 = sclk; mosi1 = mosi;
        prev = sclk; rises = 0; falls = 0; first_edge = 0; valid_cyc = 0;
        ready_v = 1'b0; sclk_v = 1'b0; ss_v = '0; rx_got = '0;
        while (valid_cyc == 0 && cyc < max_cyc) begin
            if (cyc == poke) begin
                start = 1'b1; tx_data = 32'hFF; len_m1 = 5'd3; cpha = ~pha;
                clkdiv = 16'd0; hold_cs = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
            if (sclk && !prev) rises++;
            if (!sclk && prev) falls++;
            if (sclk != prev && first_edge == 0) first_edge = cyc;
            prev = sclk;
            if (rx_valid) begin
                valid_cyc = cyc; rx_got = rx_data; ss_v = ss_n; ready_v = ready; sclk_v = sclk;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int edges;
        int extra_valid;
        logic prev;
        rst = 1'b1; start = 1'b0; tx_data = '0; len_m1 = '0; cpol = 1'b0; cpha = 1'b0;
        cs_sel = '0; clkdiv = '0; hold_cs = 1'b0; cs_release = 1'b0;
        loopback = 1'b1; miso_fix = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (3) step();
        check("rst_ss_n", ss_n, 4'hF);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        rst = 1'b0;
        step();

        // Mode 0, H=1, 8 bits, loopback.
        xfer(32'hA5, 5'd7, 0, 0, 2'd0, 16'd0, 0, 0, 100);
        check("m0_busy_c1", busy1, 1);
        check("m0_ready_c1", ready1, 0);
        check("m0_ss_c1", ss1, 4'hE);
        check("m0_mosi_first", mosi1, 1);
        check("m0_first_edge", first_edge, 2);
        check("m0_valid_cyc", valid_cyc, 19);
        check("m0_rx", rx_got, 32'hA5);
        check("m0_rises", rises, 8);
        check("m0_falls", falls, 8);
        check("m0_ss_at_valid", ss_v, 4'hF);
        check("m0_ready_at_valid", ready_v, 1);

        // Mode 3, H=4, full 32 bits.
        xfer(32'hDEADBEEF, 5'd31, 1, 1, 2'd0, 16'd3, 0, 0, 400);
        check("m3_sclk_setup", sclk1, 1);
        check("m3_first_edge", first_edge, 5);
        check("m3_valid_cyc", valid_cyc, 265);
        check("m3_rx", rx_got, 32'hDEADBEEF);
        check("m3_rises", rises, 32);
        check("m3_falls", falls, 32);
        check("m3_sclk_after", sclk_v, 1);
        step();
        check("m3_sclk_idle", sclk, 1);

        // Single-bit words, MISO held high, modes 1 and 2.
        loopback = 1'b0; miso_fix = 1'b1;
        xfer(32'h0, 5'd0, 0, 1, 2'd0, 16'd1, 0, 0, 50);
        check("m1_len1_valid_cyc", valid_cyc, 9);
        check("m1_len1_rx", rx_got, 32'h1);
        check("m1_len1_rises", rises, 1);
        check("m1_len1_falls", falls, 1);
        xfer(32'h0, 5'd0, 1, 0, 2'd0, 16'd0, 0, 0, 50);
        check("m2_len1_sclk_setup", sclk1, 1);
        check("m2_len1_valid_cyc", valid_cyc, 5);
        check("m2_len1_rx", rx_got, 32'h1);
        check("m2_len1_falls", falls, 1);
        check("m2_len1_rises", rises, 1);
        loopback = 1'b1;

        // Short loopback words in modes 1 and 2; bits above len_m1 must be ignored.
        xfer(32'hA, 5'd3, 0, 1, 2'd0, 16'd0, 0, 0, 50);
        check("m1_len4_valid_cyc", valid_cyc, 11);
        check("m1_len4_rx", rx_got, 32'hA);
        xfer(32'hF5, 5'd3, 1, 0, 2'd0, 16'd2, 0, 0, 100);
        check("m2_len4_valid_cyc", valid_cyc, 31);
        check("m2_len4_rx", rx_got, 32'h5);

        // Held chip select across two words; second start's cs_sel/cpol are ignored.
        xfer(32'h12, 5'd7, 0, 0, 2'd2, 16'd0, 1, 0, 100);
        check("hold1_ss_c1", ss1, 4'b1011);
        check("hold1_valid_cyc", valid_cyc, 19);
        check("hold1_rx", rx_got, 32'h12);
        check("hold1_ss_between", ss_v, 4'b1011);
        check("hold1_ready", ready_v, 1);
        xfer(32'h34, 5'd7, 1, 0, 2'd1, 16'd0, 1, 0, 100);
        check("hold2_ss_c1", ss1, 4'b1011);
        check("hold2_sclk_c1", sclk1, 0);
        check("hold2_valid_cyc", valid_cyc, 19);
        check("hold2_rx", rx_got, 32'h34);
        check("hold2_rises", rises, 8);
        cs_release = 1'b1;
        check("release_ss_same_cycle", ss_n, 4'b1011);
        step();
        cs_release = 1'b0;
        check("release_ss_next", ss_n, 4'hF);
        check("release_ready", ready, 1);

        // Reset at the 5th SCLK edge of a mode-0 word.
        start = 1'b1; tx_data = 32'hA5; len_m1 = 5'd7; cpol = 1'b0; cpha = 1'b0;
        cs_sel = 2'd0; clkdiv = 16'd0; hold_cs = 1'b0;
        step();
        start = 1'b0;
        edges = 0;
        prev = sclk;
        for (int c = 0; c < 40 && edges < 5; c++) begin
            step();
            if (sclk != prev) edges++;
            prev = sclk;
        end
        check("rst_mid_edge5_reached", edges, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_ss_n", ss_n, 4'hF);
        check("rst_mid_sclk", sclk, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", ready, 1);
        check("rst_mid_rx_valid", rx_valid, 0);
        check("rst_mid_rx_data", rx_data, 0);
        extra_valid = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (rx_valid) extra_valid++;
        end
        check("rst_mid_no_rx_valid", extra_valid, 0);
        xfer(32'h3C, 5'd7, 0, 0, 2'd0, 16'd0, 0, 0, 100);
        check("after_rst_valid_cyc", valid_cyc, 19);
        check("after_rst_rx", rx_got, 32'h3C);

        // Start pulsed mid-word with different settings must be ignored.
        xfer(32'h5A, 5'd7, 0, 0, 2'd0, 16'd1, 0, 5, 100);
        check("busy_start_valid_cyc", valid_cyc, 37);
        check("busy_start_rx", rx_got, 32'h5A);
        check("busy_start_ss_at_valid", ss_v, 4'hF);
        repeat (3) step();
        check("busy_start_no_restart", busy, 0);

`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b1;
        xfer(32'h01, 5'd7, 0, 0, 2'd0, 16'd0, 0, 0, 100);
        check("lsb_mosi_first", mosi1, 1);
        check("lsb_valid_cyc", valid_cyc, 19);
        check("lsb_rx", rx_got, 32'h01);
        lsb_first = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
